playbus_ctrl: RTL and testbench

PLAYBUS_CTRL -- requirements
Module: playbus_ctrl

---
 rtl/playbus_ctrl.sv | 78 +++++++
 tb/tb_playbus_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/playbus_ctrl.sv
// playbus_ctrl: bus strobe sequencer for ROM/RAM/switch/LED transfers.
// Define PLAYBUS_BLOCK_EN to enable the FUNC 7 auto-incrementing block copy.
module playbus_ctrl #(
  parameter int AW         = 4,
  parameter int STROBE_CYC = 1
) (
  input  logic          CK2HZ,
  input  logic          CLR,
  input  logic          GO,
  input  logic [2:0]    FUNC,
  input  logic [AW-1:0] ADD,
  output logic [AW-1:0] ADDR_OUT,
  output logic          n_ROMO,
  output logic          n_RAMO,
  output logic          n_RAMW,
  output logic          n_SWBEN,
  output logic          LEDLTCH,
  output logic          BUSY,
  output logic [1:0]    St
);
  typedef enum logic [1:0] {IDLE, XFER, NEXT, WAITREL} state_t;
  state_t        state;
  logic [3:0]    cnt;
  logic [AW-1:0] addr;
  logic [2:0]    func;
  logic          idle, xfer, last;
  always_ff @(posedge CK2HZ or posedge CLR)
    if (CLR) begin
      state <= IDLE;
      cnt   <= '0;
      addr  <= '0;
      func  <= '0;
    end else
      case (state)
        IDLE:
          if (GO && FUNC >= 3'd3) begin
            state <= XFER;
            cnt   <= 4'(STROBE_CYC);
            addr  <= ADD;
            func  <= FUNC;
          end
        XFER:
          if (cnt > 4'd1) cnt <= cnt - 4'd1;
          else begin
            cnt <= '0;
`ifdef PLAYBUS_BLOCK_EN
            state <= (func == 3'd7) ? NEXT : WAITREL;
`else
            state <= WAITREL;
`endif
          end
`ifdef PLAYBUS_BLOCK_EN
        NEXT:
          if (&addr) state <= WAITREL;
          else begin
            addr  <= addr + 1'b1;
            cnt   <= 4'(STROBE_CYC);
            state <= XFER;
          end
`endif
        WAITREL: if (!GO) state <= IDLE;
        default: state <= IDLE;
      endcase
  // IDLE strobes follow FUNC directly; busy strobes use only latched state
  always_comb begin
    idle     = state == IDLE;
    xfer     = state == XFER;
    last     = xfer && cnt == 4'd1;
    n_ROMO   = !(idle ? FUNC == 3'd1 : xfer && (func == 3'd3 || func >= 3'd6));
    n_RAMO   = !(idle ? FUNC == 3'd2 : xfer && func == 3'd4);
    n_RAMW   = !(last && func >= 3'd5);
    n_SWBEN  = !(xfer && func == 3'd5);
    LEDLTCH  = last && (func == 3'd3 || func == 3'd4);
    BUSY     = !idle;
    St       = state;
    ADDR_OUT = idle ? ADD : addr;
  end
endmodule

// File: tb/tb_playbus_ctrl.sv
// tb_playbus_ctrl: directed checks of playbus_ctrl with STROBE_CYC=2 (u0) and STROBE_CYC=1 (u1).
module tb_playbus_ctrl;
`ifdef PLAYBUS_BLOCK_EN
  localparam bit BLK = 1'b1;
`else
  localparam bit BLK = 1'b0;
`endif
  logic       clk = 1'b0, clr = 1'b1, go = 1'b0;
  logic [2:0] func = 3'd0;
  logic [3:0] add = 4'd0;
  logic [3:0] a0, a1;
  logic [1:0] st0, st1;
  logic       busy0, busy1;
  logic       romo0, ramo0, ramw0, swben0, led0;
  logic       romo1, ramo1, ramw1, swben1, led1;
  logic [4:0] s0, s1;
  int         n_chk = 0, n_err = 0;
  int         pulses;
  logic [15:0] mask;
  bit         saw2;
  assign s0 = {romo0, ramo0, ramw0, swben0, led0};
  assign s1 = {romo1, ramo1, ramw1, swben1, led1};
  always #5 clk = ~clk;
  playbus_ctrl #(.AW(4), .STROBE_CYC(2)) u0 (
    .CK2HZ(clk), .CLR(clr), .GO(go), .FUNC(func), .ADD(add), .ADDR_OUT(a0),
    .n_ROMO(romo0), .n_RAMO(ramo0), .n_RAMW(ramw0), .n_SWBEN(swben0),
    .LEDLTCH(led0), .BUSY(busy0), .St(st0));
  playbus_ctrl #(.AW(4), .STROBE_CYC(1)) u1 (
    .CK2HZ(clk), .CLR(clr), .GO(go), .FUNC(func), .ADD(add), .ADDR_OUT(a1),
    .n_ROMO(romo1), .n_RAMO(ramo1), .n_RAMW(ramw1), .n_SWBEN(swben1),
    .LEDLTCH(led1), .BUSY(busy1), .St(st1));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  initial begin
    #3;
    chk("rst_st", st0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_strobes", s0, 5'b11110);
    chk("rst_addr", a0, 0);
    clr = 1'b0;
    // GO ignored for FUNC 0..2
    func = 3'd1; add = 4'd5; go = 1'b1;
    #1 chk("f1_strobes", s0, 5'b01110);
    tick; tick;
    chk("f1_st", st0, 0);
    chk("f1_busy", busy0, 0);
    chk("f1_strobes_held", s0, 5'b01110);
    chk("f1_addr", a0, 5);
    func = 3'd2;
    tick; tick;
    chk("f2_st", st0, 0);
    chk("f2_strobes", s0, 5'b10110);
    func = 3'd0;
    tick;
    chk("f0_st", st0, 0);
    chk("f0_strobes", s0, 5'b11110);
    go = 1'b0;
    tick;
    // FUNC 3, 3-cycle GO pulse
    func = 3'd3; add = 4'd9; go = 1'b1;
    tick;
    chk("f3_c1_st", st0, 1);
    chk("f3_c1_strobes", s0, 5'b01110);
    chk("f3_c1_addr", a0, 9);
    tick;
    chk("f3_c2_st", st0, 1);
    chk("f3_c2_strobes", s0, 5'b01111);
    tick;
    chk("f3_wait_st", st0, 3);
    chk("f3_wait_strobes", s0, 5'b11110);
    go = 1'b0;
    tick;
    chk("f3_idle_st", st0, 0);
    tick;
    // FUNC 4
    func = 3'd4; add = 4'd1; go = 1'b1;
    tick;
    chk("f4_c1_strobes", s0, 5'b10110);
    tick;
    chk("f4_c2_strobes", s0, 5'b10111);
    go = 1'b0;
    tick; tick;
    chk("f4_idle_st", st0, 0);
    // FUNC 5 with inputs changed mid-transfer
    func = 3'd5; add = 4'd6; go = 1'b1;
    tick;
    chk("f5_c1_strobes", s0, 5'b11100);
    func = 3'd3; add = 4'd2;
    #1 chk("f5_c1_strobes_chg", s0, 5'b11100);
    chk("f5_c1_addr_chg", a0, 6);
    tick;
    chk("f5_c2_strobes", s0, 5'b11000);
    chk("f5_c2_addr", a0, 6);
    go = 1'b0;
    tick;
    chk("f5_wait_st", st0, 3);
    chk("f5_wait_addr", a0, 6);
    tick;
    chk("f5_idle_st", st0, 0);
    chk("f5_idle_addr", a0, 2);
    tick;
    // FUNC 7 block copy from 13 (u1 has STROBE_CYC=1)
    func = 3'd7; add = 4'd13; go = 1'b1;
    pulses = 0; mask = '0; saw2 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (!ramw1) begin
        pulses++;
        mask[a1] = 1'b1;
      end
      if (st1 == 2'd2) saw2 = 1'b1;
    end
    chk("f7_pulses", pulses, BLK ? 3 : 1);
    chk("f7_pulse_addrs", mask, BLK ? 16'he000 : 16'h2000);
    chk("f7_saw_next", saw2, BLK);
    chk("f7_u1_st", st1, 3);
    chk("f7_u1_addr", a1, BLK ? 15 : 13);
    chk("f7_u0_st", st0, 3);
    chk("f7_u0_addr", a0, BLK ? 15 : 13);
    go = 1'b0;
    tick;
    chk("f7_idle_st", st1, 0);
    tick;
    // CLR during the second XFER of a block (u0)
    add = 4'd4; go = 1'b1;
    tick; tick; tick; tick;
    chk("clr_pre_st", st0, BLK ? 1 : 3);
    chk("clr_pre_romo", romo0, BLK ? 0 : 1);
    chk("clr_pre_addr", a0, BLK ? 5 : 4);
    #1 clr = 1'b1;
    #1 chk("clr_st", st0, 0);
    chk("clr_busy", busy0, 0);
    chk("clr_strobes", s0, 5'b11110);
    chk("clr_u1_strobes", s1, 5'b11110);
    clr = 1'b0; go = 1'b0; add = 4'd10;
    #1 chk("clr_addr_follow", a0, 10);
    tick; tick;
    chk("clr_stay_idle", st0, 0);
    chk("clr_stay_strobes", s0, 5'b11110);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
